// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: word width, starvation
// limit defaults and the ownership FSM encoding.
package dmem_arbiter_pkg;
    localparam int WORD_LEN_DEF     = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } own_state_e;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive lost cycles for one requester; flags when
// the count has reached the limit so the requester can be forced to win.
module dmem_arbiter_starve_counter #(
    parameter int CNT_W = 3,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares dataMEM between the CPU MEM stage (port C) and a debug/loader port
// (port D), stalling the CPU when it loses and forcing a win after starvation.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WORD_LEN     = WORD_LEN_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [WORD_LEN-1:0] cpu_addr,
    input  logic [WORD_LEN-1:0] cpu_wdata,
    output logic [WORD_LEN-1:0] cpu_rdata,
    output logic                cpu_stall,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic                dbg_lock,
    input  logic [WORD_LEN-1:0] dbg_addr,
    input  logic [WORD_LEN-1:0] dbg_wdata,
    output logic [WORD_LEN-1:0] dbg_rdata,
    output logic                dbg_ack,
    output logic                mem_we,
    output logic                mem_re,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_din,
    input  logic [WORD_LEN-1:0] mem_dout
);
    own_state_e          state_q, state_d;
    logic                ack_q, ack_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic                gnt_c, gnt_d;
    logic                cstarve_lim, dstarve_lim;

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (state_q == S_CPU) begin
            gnt_c = cpu_req & ~(dbg_req & dstarve_lim);
            gnt_d = dbg_req & ~gnt_c;
        end else begin
            gnt_d = dbg_req & ~(cpu_req & cstarve_lim);
            gnt_c = cpu_req & ~gnt_d;
        end
        // Port D holds ownership only while it keeps winning with lock high;
        // release, lock drop or a forced CPU win all fall back to S_CPU.
        state_d = (gnt_d & dbg_lock) ? S_DBG : S_CPU;
        ack_d   = gnt_d;
        rdata_d = (gnt_d & ~dbg_we) ? mem_dout : rdata_q;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt_c) begin
            mem_we   = cpu_we;
            mem_re   = ~cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (gnt_d) begin
            mem_we   = dbg_we;
            mem_re   = ~dbg_we;
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_CPU;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    dmem_arbiter_starve_counter #(.CNT_W(CNT_W), .LIMIT(STARVE_LIMIT)) u_cstarve (
        .clk      (clk),
        .rst      (rst),
        .inc      (cpu_req & ~gnt_c),
        .clr      (~cpu_req | gnt_c),
        .at_limit (cstarve_lim)
    );

    dmem_arbiter_starve_counter #(.CNT_W(CNT_W), .LIMIT(STARVE_LIMIT)) u_dstarve (
        .clk      (clk),
        .rst      (rst),
        .inc      (dbg_req & ~gnt_d),
        .clr      (~dbg_req | gnt_d),
        .at_limit (dstarve_lim)
    );

    assign cpu_stall = cpu_req & ~gnt_c;
    assign cpu_rdata = gnt_c ? mem_dout : '0;
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;
endmodule
